mul_share_arbiter: RTL and testbench



---
 rtl/mul_share_arbiter.sv | 113 +++++++++++
 tb/tb_mul_share_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one external 4x4 unsigned multiplier among NUM_REQ
// requesters; one transaction in flight, product returned on a valid/ready channel.
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 1,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [4*NUM_REQ-1:0]   req_a,
    input  logic [4*NUM_REQ-1:0]   req_b,
    output logic [3:0]             mul_a,
    output logic [3:0]             mul_b,
    input  logic [7:0]             mul_p,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [7:0]             rsp_p,
    output logic [IDW-1:0]         rsp_id,
    output logic                   busy
);

    localparam int CW = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IDW-1:0]  ptr;
    logic [CW-1:0]   cnt;
    logic [3:0]      op_a;
    logic [3:0]      op_b;
    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic [IDW-1:0]  cand;

    // Search starts just after the last winner so the previous owner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (win_found) state_nx = CALC;
            CALC: if (cnt == CW'(1)) state_nx = RESP;
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = (state != IDLE);
        if (state == IDLE && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
        if (state == RESP) begin
            rsp_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= IDW'(NUM_REQ - 1);
            op_a   <= '0;
            op_b   <= '0;
            rsp_p  <= '0;
            rsp_id <= '0;
            cnt    <= '0;
        end else begin
            if (state == IDLE && win_found) begin
                op_a   <= req_a[4*win_idx +: 4];
                op_b   <= req_b[4*win_idx +: 4];
                rsp_id <= win_idx;
                ptr    <= win_idx;
                cnt    <= CW'(MUL_LAT);
            end else if (state == CALC) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    rsp_p <= mul_p;
                end
            end
        end
    end

    assign mul_a = op_a;
    assign mul_b = op_b;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized bench for mul_share_arbiter: timeline reference model plus response
// scoreboard on the MUL_LAT=1 instance, directed latency checks on a MUL_LAT=3 instance.
module tb_mul_share_arbiter;

    localparam int N    = 4;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [4*N-1:0] req_a;
    logic [4*N-1:0] req_b;
    logic [3:0]     mul_a;
    logic [3:0]     mul_b;
    logic [7:0]     mul_p;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [7:0]     rsp_p;
    logic [1:0]     rsp_id;
    logic           busy;

    logic [N-1:0]   v3;
    logic [N-1:0]   rdy3;
    logic [4*N-1:0] a3;
    logic [4*N-1:0] b3;
    logic [3:0]     ma3;
    logic [3:0]     mb3;
    logic [7:0]     mp3;
    logic           rv3;
    logic           rr3;
    logic [7:0]     rp3;
    logic [1:0]     rid3;
    logic           busy3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // The environment's shared multiplier
    assign mul_p = mul_a * mul_b;
    assign mp3   = ma3 * mb3;

    mul_share_arbiter #(.NUM_REQ(N), .MUL_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p), .rsp_id(rsp_id),
        .busy(busy)
    );

    mul_share_arbiter #(.NUM_REQ(N), .MUL_LAT(LAT3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3),
        .req_a(a3), .req_b(b3), .mul_a(ma3), .mul_b(mb3), .mul_p(mp3),
        .rsp_valid(rv3), .rsp_ready(rr3), .rsp_p(rp3), .rsp_id(rid3),
        .busy(busy3)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int id;
        int p;
    } exp_t;
    exp_t sb[$];

    // Reference model: a grant may happen only once the previous response has been
    // consumed; round-robin picks the first valid requester after the last winner.
    int       cyc = 0;
    int       free_at = 0;
    int       resp_start = 0;
    bit       resp_pending = 0;
    int       last = N - 1;
    int       win;
    bit       idle;
    logic [3:0] cur_a = '0;
    logic [3:0] cur_b = '0;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            last         = N - 1;
            cur_a        = '0;
            cur_b        = '0;
            free_at      = cyc + 1;
            resp_pending = 0;
        end else begin
            idle = (cyc >= free_at);
            check("busy", busy, !idle);
            check("mul_a", mul_a, cur_a);
            check("mul_b", mul_b, cur_b);
            check("rsp_valid", rsp_valid, (resp_pending && cyc >= resp_start));
            win = -1;
            if (idle) begin
                for (int k = 1; k <= N; k++) begin
                    if (win < 0 && req_valid[(last + k) % N]) win = (last + k) % N;
                end
            end
            check("req_ready", req_ready, (win >= 0) ? (1 << win) : 0);
            if (win >= 0) begin
                cur_a = req_a[4*win +: 4];
                cur_b = req_b[4*win +: 4];
                sb.push_back('{id: win, p: int'(cur_a) * int'(cur_b)});
                last         = win;
                resp_start   = cyc + LAT + 1;
                resp_pending = 1;
                free_at      = 1 << 30;
            end
            if (resp_pending && cyc >= resp_start && rsp_ready) begin
                resp_pending = 0;
                free_at      = cyc + 1;
            end
        end
        cyc++;
    end

    // Response monitor: every presented response must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_spurious", 1, 0);
            end else begin
                check("rsp_id", rsp_id, sb[0].id);
                check("rsp_p", rsp_p, sb[0].p);
                if (rsp_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rand_nib();
        int unsigned r;
        r = $urandom_range(5, 0);
        if (r == 0) return 4'd0;
        if (r == 1) return 4'd15;
        return 4'($urandom_range(15, 0));
    endfunction

    task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[4*i +: 4] = a;
        req_b[4*i +: 4] = b;
    endtask

    task automatic issue(input int i, input logic [3:0] a, input logic [3:0] b);
        bit got;
        got = 0;
        set_ops(i, a, b);
        req_valid[i] = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i] && !rst) got = 1;
            tick();
        end
        req_valid[i] = 1'b0;
        check("issue_accepted", got, 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) break;
        end
        tick();
    endtask

    task automatic random_phase(input int n, input int raise_mod, input int drop_mod,
                                input int rdy_mod);
        logic [N-1:0] acc;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) req_valid[i] = 1'b0;
                else if (req_valid[i] && drop_mod != 0 && $urandom_range(drop_mod - 1, 0) == 0)
                    req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(raise_mod - 1, 0) == 0) begin
                    set_ops(i, rand_nib(), rand_nib());
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = (rdy_mod == 0) ? 1'b1 : ($urandom_range(rdy_mod - 1, 0) != 0);
        end
    endtask

    task automatic t6_op(input int i, input logic [3:0] a, input logic [3:0] b);
        int rc;
        bit got;
        got = 0;
        a3[4*i +: 4] = a;
        b3[4*i +: 4] = b;
        v3 = N'(1 << i);
        rr3 = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rdy3 != 0) begin
                got = 1;
                check("t6_ready", rdy3, 1 << i);
            end
            tick();
        end
        check("t6_grant", got, 1);
        v3 = '0;
        rc = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rv3) break;
            check("t6_busy", busy3, 1);
            rc++;
            tick();
        end
        check("t6_latency", rc, LAT3 + 1);
        check("t6_rsp_p", rp3, int'(a) * int'(b));
        check("t6_rsp_id", rid3, i);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        v3 = '0;
        a3 = '0;
        b3 = '0;
        rr3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_rsp_p", rsp_p, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_req_ready", req_ready, 0);
        tick();

        // Single transaction and operand corners
        rsp_ready = 1'b1;
        issue(1, 4'd3, 4'd5);
        wait_idle();
        issue(0, 4'd15, 4'd15);
        wait_idle();
        issue(2, 4'd0, 4'd9);
        wait_idle();
        issue(3, 4'd1, 4'd15);
        wait_idle();
        issue(1, 4'd8, 4'd8);
        wait_idle();

        // Consumer stalls the response for several cycles
        rsp_ready = 1'b0;
        issue(2, 4'd6, 4'd7);
        repeat (6) tick();
        rsp_ready = 1'b1;
        wait_idle();

        // All requesters saturating, consumer always ready
        random_phase(60, 1, 0, 0);
        // Mixed random traffic with drops and stalls
        random_phase(1500, 3, 16, 4);

        // Reset while a transaction is in CALC
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_ops(i, rand_nib(), rand_nib());
        req_valid = '1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready != 0) break;
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rsp_valid", rsp_valid, 0);
        check("post_rst_grant0", req_ready, 1);
        tick();
        random_phase(30, 1, 0, 0);

        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();

        // Longer multiplier latency instance
        t6_op(2, 4'd7, 4'd9);
        t6_op(0, 4'd15, 4'd15);
        t6_op(3, 4'd4, 4'd0);

        repeat (3) tick();
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
